bitstream_packer: RTL

//  Output stage placed directly after the entropy encoder's carry-propagation output.

---
 rtl/bitstream_packer_if.sv | 30 +++
 rtl/bitstream_packer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bitstream_packer_if.sv
// Handshake bundle between the entropy-encoder byte source, the bitstream packer
// and the downstream word consumer.
interface bitstream_packer_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_BYTES = 4
);
  localparam int NBW = $clog2(WORD_BYTES) + 1;

  logic [BYTE_WIDTH-1:0]            in_bit_1;
  logic [BYTE_WIDTH-1:0]            in_bit_2;
  logic [1:0]                       in_flag;
  logic                             in_flush;
  logic [BYTE_WIDTH*WORD_BYTES-1:0] out_word;
  logic [NBW-1:0]                   out_nbytes;
  logic                             out_valid;
  logic                             out_last;
  logic                             out_ready;
  logic                             almost_full;
  logic                             overflow;

  modport master (
    output in_bit_1, in_bit_2, in_flag, in_flush, out_ready,
    input  out_word, out_nbytes, out_valid, out_last, almost_full, overflow
  );

  modport slave (
    input  in_bit_1, in_bit_2, in_flag, in_flush, out_ready,
    output out_word, out_nbytes, out_valid, out_last, almost_full, overflow
  );
endinterface

// File: rtl/bitstream_packer.sv
// Packs 0-2 encoder bytes per cycle through a circular byte FIFO into big-endian
// words; a flush drains the residue as a zero-padded word flagged out_last.
module bitstream_packer #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic               top_clk,
  input  logic               top_reset_n,
  bitstream_packer_if.slave  bus
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int NBW = $clog2(WORD_BYTES) + 1;
  localparam int WW  = BYTE_WIDTH * WORD_BYTES;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                r_state;
  logic [BYTE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [WW-1:0]         r_out_word;
  logic [NBW-1:0]        r_out_nbytes;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_overflow;

  logic [1:0]            w_n_req;
  logic [1:0]            w_n_in;
  logic [CW-1:0]         w_free;
  logic                  w_final;
  logic                  w_avail;
  logic                  w_load;
  logic                  w_last_accept;
  logic [NBW-1:0]        w_n_out;
  logic [WW-1:0]         w_word;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_n_req = 2'd0;
    if (r_state == ST_RUN) begin
      case (bus.in_flag)
        2'b01:   w_n_req = 2'd1;
        2'b10:   w_n_req = 2'd2;
        default: w_n_req = 2'd0;
      endcase
    end

    // Space comes from the pre-dequeue count: a same-cycle read frees nothing.
    w_free = CW'(FIFO_DEPTH) - r_count;
    w_n_in = (CW'(w_n_req) > w_free) ? w_free[1:0] : w_n_req;

    w_final       = (r_state == ST_FLUSH) && (r_count <= CW'(WORD_BYTES));
    w_avail       = (r_state == ST_RUN) ? (r_count >= CW'(WORD_BYTES))
                                        : !(r_out_valid && r_out_last);
    w_load        = (!r_out_valid || bus.out_ready) && w_avail;
    w_last_accept = r_out_valid && r_out_last && bus.out_ready;

    w_n_out = '0;
    if (w_load) w_n_out = w_final ? NBW'(r_count) : NBW'(WORD_BYTES);

    w_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (NBW'(i) < w_n_out)
        w_word[(WORD_BYTES-1-i)*BYTE_WIDTH +: BYTE_WIDTH] = r_mem[r_rd_ptr + PW'(i)];
    end
  end

  // NOTE: the byte store carries no reset; pointers and count define which entries are live.
  always_ff @(posedge top_clk) begin
    if (w_n_in != 2'd0) r_mem[r_wr_ptr] <= bus.in_bit_1;
    if (w_n_in == 2'd2) r_mem[r_wr_ptr + PW'(1)] <= bus.in_bit_2;
  end

  // NOTE: all registered state uses non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge top_clk or negedge top_reset_n) begin
    if (!top_reset_n) begin
      r_state      <= ST_RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_word   <= '0;
      r_out_nbytes <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_count <= r_count + CW'(w_n_in) - CW'(w_n_out);
      if (w_n_req != w_n_in) r_overflow <= 1'b1;

      if (w_load) begin
        r_out_word   <= w_word;
        r_out_nbytes <= w_n_out;
        r_out_last   <= w_final;
        r_out_valid  <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end

      // Frame terminator accepted: restart the next frame from a clean FIFO origin.
      if (w_last_accept) begin
        r_state  <= ST_RUN;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_n_in);
        r_rd_ptr <= r_rd_ptr + PW'(w_n_out);
        if (r_state == ST_RUN && bus.in_flush) r_state <= ST_FLUSH;
      end
    end
  end

  assign bus.out_word    = r_out_word;
  assign bus.out_nbytes  = r_out_nbytes;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign bus.overflow    = r_overflow;
  assign bus.almost_full = (r_count >= CW'(FIFO_DEPTH - AF_MARGIN));
endmodule
